match_ctrl: RTL and testbench
=============================

MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 7: score that ends the match; legal range 1..7.
REQ-002 Parameter MATCH_SECONDS, default 150: match length in seconds; legal range 1..255.
REQ-003 Parameter PAUSE_TICKS, default 2: sec_tick count spent in PAUSE after each goal; legal range 1..15.
REQ-004 clock  in  1  single system clock; all state on posedge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; starts a match from IDLE or GAME_OVER.
REQ-007 goal_p1  in  1  level from puck logic; a rising edge is one goal for player 1.
REQ-008 goal_p2  in  1  level; a rising edge is one goal for player 2.
REQ-009 sec_tick  in  1  one-cycle pulse per second from the timer stage.
REQ-010 score_p1, score_p2  out  3  current scores.
REQ-011 time_left  out  8  seconds remaining.
REQ-012 enable_timer  out  1  high only in PLAY; gates the timer stage.
REQ-013 clear_sig  out  1  one-cycle pulse on match start; clears the timer stage.
REQ-014 state  out  2  IDLE=0, PLAY=1, PAUSE=2, GAME_OVER=3.
REQ-015 winner  out  2  0=none, 1=player 1, 2=player 2, 3=draw; valid in GAME_OVER.

Function
REQ-016 Goals SHALL be rising-edge detected with a one-flop history; a level held high counts once.
REQ-017 IDLE: start -> PLAY; scores=0, time_left=MATCH_SECONDS, clear_sig=1 in that cycle.
REQ-018 PLAY: one goal edge increments that score on the next clock edge, then the FSM enters PAUSE with pause counter=PAUSE_TICKS.
REQ-019 Goal edges on both inputs in the same cycle SHALL both be ignored; no score change, no state change.
REQ-020 PLAY: sec_tick decrements time_left by 1; time_left saturates at 0 and never wraps.
REQ-021 A goal that brings a score to WIN_SCORE SHALL go to GAME_OVER (not PAUSE) with winner set to that player.
REQ-022 time_left reaching 0 in PLAY SHALL go to GAME_OVER; winner is the higher score, or 3 on a tie.
REQ-023 If a goal edge and the final sec_tick occur in the same cycle, the goal counts first, then the timeout is evaluated.
REQ-024 PAUSE: goal edges are ignored; each sec_tick decrements the pause counter; at 0 -> PLAY; time_left is frozen.
REQ-025 GAME_OVER: all outputs hold; start re-runs the REQ-017 initialisation and enters PLAY.
REQ-026 start outside IDLE and GAME_OVER SHALL be ignored.
REQ-027 Scores never exceed WIN_SCORE and SHALL NOT wrap.

Reset
REQ-028 reset SHALL asynchronously force state=IDLE, scores=0, time_left=MATCH_SECONDS, winner=0, enable_timer=0, clear_sig=0, pause counter=0, and edge history=0.
REQ-029 Reset asserted mid-match SHALL abandon the match with no residual state.

Configuration
REQ-030 Macro MATCH_CTRL_SUDDEN_DEATH_EN:
- When defined, a tied timeout enters PLAY with time_left=0 and timer decrement disabled; the next counted goal ends the match with that player as winner.
- When undefined, a tied timeout ends the match with winner=3.

Structure
REQ-031 A shared package SHALL hold the state encoding, the winner encoding, and the width constants.
REQ-032 One sub-module, goal_edge_det, SHALL provide the two-input rising-edge detector with the simultaneous-goal filter.

Verification
REQ-033 Run these directed scenarios:
- reset, then start, then goal_p1 held high for 10 cycles -> score_p1=1 exactly once; state=PAUSE; after 2 sec_ticks state=PLAY.
- goal_p1 and goal_p2 rise in the same cycle -> both scores unchanged; state stays PLAY.
- 7 separated goal_p2 edges -> score_p2=7; state=GAME_OVER; winner=2; further goals are ignored.
- 150 sec_ticks with scores 2-1 -> time_left=0; GAME_OVER; winner=1; time_left does not wrap below 0.
- Tie at timeout -> winner=3 without the macro; with the macro, PLAY continues and the next goal_p1 gives winner=1.
- reset pulse mid-PAUSE, then start -> scores=0, time_left=150, clear_sig high for exactly one cycle.

Source files
------------

// File: rtl/match_ctrl_pkg.sv
// Shared definitions for the match controller: state and winner encodings,
// datapath widths, and the timeout winner decision.
package match_ctrl_pkg;

    localparam int SCORE_W = 3;
    localparam int TIME_W  = 8;
    localparam int PAUSE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAY      = 2'd1,
        ST_PAUSE     = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2,
        WIN_DRAW = 2'd3
    } winner_t;

    // Winner when the clock runs out: higher score wins, equal scores draw.
    function automatic winner_t timeout_winner(input logic [SCORE_W-1:0] s1,
                                               input logic [SCORE_W-1:0] s2);
        winner_t w;
        if (s1 > s2) begin
            w = WIN_P1;
        end else if (s2 > s1) begin
            w = WIN_P2;
        end else begin
            w = WIN_DRAW;
        end
        return w;
    endfunction

endpackage

// File: rtl/match_ctrl_goal_edge_det.sv
// Two-input goal rising-edge detector. A held level counts once; when both
// players' goals rise in the same cycle neither edge is reported.
module goal_edge_det
    import match_ctrl_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic goal_p1,
    input  logic goal_p2,
    output logic edge_p1,
    output logic edge_p2
);

    logic hist_p1_r;
    logic hist_p2_r;
    logic rise_p1_s;
    logic rise_p2_s;

    // One-flop history of each goal level, cleared by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist_p1_r <= 1'b0;
            hist_p2_r <= 1'b0;
        end else begin
            hist_p1_r <= goal_p1;
            hist_p2_r <= goal_p2;
        end
    end

    // Raw rising edges, then suppress both when they coincide.
    always_comb begin
        rise_p1_s = goal_p1 & ~hist_p1_r;
        rise_p2_s = goal_p2 & ~hist_p2_r;
        if (rise_p1_s && rise_p2_s) begin
            edge_p1 = 1'b0;
            edge_p2 = 1'b0;
        end else begin
            edge_p1 = rise_p1_s;
            edge_p2 = rise_p2_s;
        end
    end

endmodule

// File: rtl/match_ctrl.sv
// Match controller: scores, match clock, post-goal pause and winner decision.
// Optional feature macro MATCH_CTRL_SUDDEN_DEATH_EN: a tied timeout keeps
// playing with the clock stopped at 0 and the next counted goal wins.
module match_ctrl
    import match_ctrl_pkg::*;
#(
    parameter int WIN_SCORE     = 7,
    parameter int MATCH_SECONDS = 150,
    parameter int PAUSE_TICKS   = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       goal_p1,
    input  logic       goal_p2,
    input  logic       sec_tick,
    output logic [2:0] score_p1,
    output logic [2:0] score_p2,
    output logic [7:0] time_left,
    output logic       enable_timer,
    output logic       clear_sig,
    output logic [1:0] state,
    output logic [1:0] winner
);

    localparam logic [SCORE_W-1:0] WIN_S   = SCORE_W'(WIN_SCORE);
    localparam logic [TIME_W-1:0]  MATCH_T = TIME_W'(MATCH_SECONDS);
    localparam logic [PAUSE_W-1:0] PAUSE_T = PAUSE_W'(PAUSE_TICKS);

    state_t              state_r, state_nxt_s;
    logic [SCORE_W-1:0]  score_p1_r, score_p2_r, s1_upd_s, s2_upd_s, s1_nxt_s, s2_nxt_s;
    logic [TIME_W-1:0]   time_r, time_upd_s, time_nxt_s;
    logic [PAUSE_W-1:0]  pause_cnt_r, pause_nxt_s;
    winner_t             winner_r, winner_nxt_s;
    logic                sd_r, sd_nxt_s;
    logic                enable_timer_r, enable_nxt_s;
    logic                clear_r, clear_nxt_s;
    logic                edge_p1_s, edge_p2_s;
    logic                start_ok_s, play_s, goal_s, win_goal_s, timeout_s;

    goal_edge_det u_goal_edge_det (
        .clock   (clock),
        .reset   (reset),
        .goal_p1 (goal_p1),
        .goal_p2 (goal_p2),
        .edge_p1 (edge_p1_s),
        .edge_p2 (edge_p2_s)
    );

    // Decode this cycle's events: goal first, then the clock, then timeout.
    always_comb begin
        start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_GAME_OVER));
        play_s     = (state_r == ST_PLAY);
        goal_s     = play_s && (edge_p1_s || edge_p2_s);
        if (play_s && edge_p1_s) begin
            s1_upd_s = score_p1_r + 3'd1;
        end else begin
            s1_upd_s = score_p1_r;
        end
        if (play_s && edge_p2_s) begin
            s2_upd_s = score_p2_r + 3'd1;
        end else begin
            s2_upd_s = score_p2_r;
        end
        if (play_s && !sd_r && sec_tick && (time_r != 8'd0)) begin
            time_upd_s = time_r - 8'd1;
        end else begin
            time_upd_s = time_r;
        end
        win_goal_s = goal_s && ((s1_upd_s == WIN_S) || (s2_upd_s == WIN_S));
        timeout_s  = play_s && !sd_r && (time_upd_s == 8'd0);
    end

`ifdef MATCH_CTRL_SUDDEN_DEATH_EN
    logic tie_s;
    assign tie_s = (s1_upd_s == s2_upd_s);
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_GAME_OVER: begin
                if (start) begin
                    state_nxt_s = ST_PLAY;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_PLAY: begin
                if (win_goal_s || (sd_r && goal_s)) begin
                    state_nxt_s = ST_GAME_OVER;
                end else if (timeout_s) begin
`ifdef MATCH_CTRL_SUDDEN_DEATH_EN
                    if (tie_s) begin
                        state_nxt_s = ST_PLAY;
                    end else begin
                        state_nxt_s = ST_GAME_OVER;
                    end
`else
                    state_nxt_s = ST_GAME_OVER;
`endif
                end else if (goal_s) begin
                    state_nxt_s = ST_PAUSE;
                end else begin
                    state_nxt_s = ST_PLAY;
                end
            end
            ST_PAUSE: begin
                if (sec_tick && (pause_cnt_r <= 4'd1)) begin
                    state_nxt_s = ST_PLAY;
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        s1_nxt_s     = score_p1_r;
        s2_nxt_s     = score_p2_r;
        time_nxt_s   = time_r;
        pause_nxt_s  = pause_cnt_r;
        winner_nxt_s = winner_r;
        sd_nxt_s     = sd_r;
        case (state_r)
            ST_IDLE, ST_GAME_OVER: begin
                if (start) begin
                    s1_nxt_s     = 3'd0;
                    s2_nxt_s     = 3'd0;
                    time_nxt_s   = MATCH_T;
                    pause_nxt_s  = 4'd0;
                    winner_nxt_s = WIN_NONE;
                    sd_nxt_s     = 1'b0;
                end else begin
                    s1_nxt_s     = score_p1_r;
                    s2_nxt_s     = score_p2_r;
                end
            end
            ST_PLAY: begin
                s1_nxt_s   = s1_upd_s;
                s2_nxt_s   = s2_upd_s;
                time_nxt_s = time_upd_s;
                if (state_nxt_s == ST_PAUSE) begin
                    pause_nxt_s = PAUSE_T;
                end else begin
                    pause_nxt_s = pause_cnt_r;
                end
                if (state_nxt_s == ST_GAME_OVER) begin
                    sd_nxt_s = 1'b0;
                    if (win_goal_s || (sd_r && goal_s)) begin
                        winner_nxt_s = edge_p1_s ? WIN_P1 : WIN_P2;
                    end else begin
                        winner_nxt_s = timeout_winner(s1_upd_s, s2_upd_s);
                    end
                end else if ((state_nxt_s == ST_PLAY) && timeout_s) begin
                    // Only reachable on a tied timeout with sudden death built in.
                    sd_nxt_s = 1'b1;
                end else begin
                    sd_nxt_s = sd_r;
                end
            end
            ST_PAUSE: begin
                if (sec_tick && (pause_cnt_r != 4'd0)) begin
                    pause_nxt_s = pause_cnt_r - 4'd1;
                end else begin
                    pause_nxt_s = pause_cnt_r;
                end
            end
            default: begin
                s1_nxt_s = score_p1_r;
            end
        endcase
        enable_nxt_s = (state_nxt_s == ST_PLAY) && !sd_nxt_s;
        clear_nxt_s  = start_ok_s;
    end

    // Datapath and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            score_p1_r     <= 3'd0;
            score_p2_r     <= 3'd0;
            time_r         <= MATCH_T;
            pause_cnt_r    <= 4'd0;
            winner_r       <= WIN_NONE;
            sd_r           <= 1'b0;
            enable_timer_r <= 1'b0;
            clear_r        <= 1'b0;
        end else begin
            score_p1_r     <= s1_nxt_s;
            score_p2_r     <= s2_nxt_s;
            time_r         <= time_nxt_s;
            pause_cnt_r    <= pause_nxt_s;
            winner_r       <= winner_nxt_s;
            sd_r           <= sd_nxt_s;
            enable_timer_r <= enable_nxt_s;
            clear_r        <= clear_nxt_s;
        end
    end

    assign score_p1     = score_p1_r;
    assign score_p2     = score_p2_r;
    assign time_left    = time_r;
    assign enable_timer = enable_timer_r;
    assign clear_sig    = clear_r;
    assign state        = state_r;
    assign winner       = winner_r;

endmodule

// File: tb/tb_match_ctrl.sv
// Self-checking bench for match_ctrl: a vector table plus directed sequences,
// expected output records queued on drive and compared after the clock edge.
module tb_match_ctrl;

    localparam logic [1:0] S_IDLE = 2'd0, S_PLAY = 2'd1, S_PAUSE = 2'd2, S_OVER = 2'd3;
    localparam logic [1:0] W_NONE = 2'd0, W_P1 = 2'd1, W_P2 = 2'd2, W_DRAW = 2'd3;

    typedef struct packed {
        logic [1:0] st;
        logic [2:0] s1;
        logic [2:0] s2;
        logic [7:0] tl;
        logic [1:0] win;
        logic       en;
        logic       clr;
    } exp_t;

    typedef struct packed {
        logic st;
        logic g1;
        logic g2;
        logic tk;
        exp_t e;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset, start, goal_p1, goal_p2, sec_tick;
    logic [2:0] score_p1, score_p2;
    logic [7:0] time_left;
    logic       enable_timer, clear_sig;
    logic [1:0] state, winner;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    vec_t tbl[20];

    // Free-running clock.
    always #5 clock = ~clock;

    match_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .goal_p1      (goal_p1),
        .goal_p2      (goal_p2),
        .sec_tick     (sec_tick),
        .score_p1     (score_p1),
        .score_p2     (score_p2),
        .time_left    (time_left),
        .enable_timer (enable_timer),
        .clear_sig    (clear_sig),
        .state        (state),
        .winner       (winner)
    );

    function automatic exp_t mk_e(input logic [1:0] st, input logic [2:0] s1, input logic [2:0] s2,
                                  input logic [7:0] tl, input logic [1:0] win, input logic en, input logic clr);
        exp_t e;
        e.st = st; e.s1 = s1; e.s2 = s2; e.tl = tl; e.win = win; e.en = en; e.clr = clr;
        return e;
    endfunction

    function automatic vec_t mk_v(input logic st, input logic g1, input logic g2, input logic tk, input exp_t e);
        vec_t v;
        v.st = st; v.g1 = g1; v.g2 = g2; v.tk = tk; v.e = e;
        return v;
    endfunction

    task automatic check(input string tag, input string fld, input int act, input int ex);
        n_checks++;
        if (act != ex) begin
            n_fail++;
            $display("FAIL %s %s: got %0d expected %0d", tag, fld, act, ex);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e);
        check(tag, "state",        int'(state),        int'(e.st));
        check(tag, "score_p1",     int'(score_p1),     int'(e.s1));
        check(tag, "score_p2",     int'(score_p2),     int'(e.s2));
        check(tag, "time_left",    int'(time_left),    int'(e.tl));
        check(tag, "winner",       int'(winner),       int'(e.win));
        check(tag, "enable_timer", int'(enable_timer), int'(e.en));
        check(tag, "clear_sig",    int'(clear_sig),    int'(e.clr));
    endtask

    task automatic step(input string tag, input logic st, input logic g1, input logic g2,
                        input logic tk, input exp_t e);
        exp_t got_e;
        @(negedge clock);
        start = st; goal_p1 = g1; goal_p2 = g2; sec_tick = tk;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        got_e = exp_q.pop_front();
        cmp(tag, got_e);
    endtask

    task automatic do_reset();
        @(negedge clock);
        start = 1'b0; goal_p1 = 1'b0; goal_p2 = 1'b0; sec_tick = 1'b0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic restart(input string tag);
        do_reset();
        step(tag, 1'b1, 1'b0, 1'b0, 1'b0, mk_e(S_PLAY, 3'd0, 3'd0, 8'd150, W_NONE, 1'b1, 1'b1));
    endtask

    // Goal for player p, then drop the level and sit out the two pause ticks.
    task automatic goal_seq(input string tag, input int p, input logic [2:0] s1, input logic [2:0] s2,
                            input logic [7:0] tl);
        step(tag, 1'b0, p == 1, p == 2, 1'b0, mk_e(S_PAUSE, s1, s2, tl, W_NONE, 1'b0, 1'b0));
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, mk_e(S_PAUSE, s1, s2, tl, W_NONE, 1'b0, 1'b0));
        step(tag, 1'b0, 1'b0, 1'b0, 1'b1, mk_e(S_PAUSE, s1, s2, tl, W_NONE, 1'b0, 1'b0));
        step(tag, 1'b0, 1'b0, 1'b0, 1'b1, mk_e(S_PLAY,  s1, s2, tl, W_NONE, 1'b1, 1'b0));
    endtask

    // n play-time ticks starting from a full clock of 150 seconds.
    task automatic run_ticks(input string tag, input int n, input logic [2:0] s1, input logic [2:0] s2);
        for (int k = 1; k <= n; k++) begin
            step(tag, 1'b0, 1'b0, 1'b0, 1'b1, mk_e(S_PLAY, s1, s2, 8'(150 - k), W_NONE, 1'b1, 1'b0));
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; goal_p1 = 1'b0; goal_p2 = 1'b0; sec_tick = 1'b0;

        tbl[0]  = mk_v(1'b1, 1'b0, 1'b0, 1'b0, mk_e(S_PLAY,  3'd0, 3'd0, 8'd150, W_NONE, 1'b1, 1'b1));
        tbl[1]  = mk_v(1'b0, 1'b0, 1'b0, 1'b0, mk_e(S_PLAY,  3'd0, 3'd0, 8'd150, W_NONE, 1'b1, 1'b0));
        for (int i = 2; i < 12; i++) begin
            // goal_p1 held high for 10 cycles: counted once
            tbl[i] = mk_v(1'b0, 1'b1, 1'b0, 1'b0, mk_e(S_PAUSE, 3'd1, 3'd0, 8'd150, W_NONE, 1'b0, 1'b0));
        end
        tbl[12] = mk_v(1'b0, 1'b0, 1'b0, 1'b1, mk_e(S_PAUSE, 3'd1, 3'd0, 8'd150, W_NONE, 1'b0, 1'b0));
        tbl[13] = mk_v(1'b0, 1'b0, 1'b0, 1'b1, mk_e(S_PLAY,  3'd1, 3'd0, 8'd150, W_NONE, 1'b1, 1'b0));
        tbl[14] = mk_v(1'b0, 1'b1, 1'b1, 1'b0, mk_e(S_PLAY,  3'd1, 3'd0, 8'd150, W_NONE, 1'b1, 1'b0));
        tbl[15] = mk_v(1'b0, 1'b0, 1'b0, 1'b0, mk_e(S_PLAY,  3'd1, 3'd0, 8'd150, W_NONE, 1'b1, 1'b0));
        tbl[16] = mk_v(1'b0, 1'b0, 1'b0, 1'b1, mk_e(S_PLAY,  3'd1, 3'd0, 8'd149, W_NONE, 1'b1, 1'b0));
        tbl[17] = mk_v(1'b1, 1'b0, 1'b0, 1'b0, mk_e(S_PLAY,  3'd1, 3'd0, 8'd149, W_NONE, 1'b1, 1'b0));
        tbl[18] = mk_v(1'b0, 1'b0, 1'b1, 1'b1, mk_e(S_PAUSE, 3'd1, 3'd1, 8'd148, W_NONE, 1'b0, 1'b0));
        tbl[19] = mk_v(1'b0, 1'b0, 1'b0, 1'b1, mk_e(S_PAUSE, 3'd1, 3'd1, 8'd148, W_NONE, 1'b0, 1'b0));

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        cmp("reset", mk_e(S_IDLE, 3'd0, 3'd0, 8'd150, W_NONE, 1'b0, 1'b0));
        @(negedge clock);
        reset = 1'b0;

        // Vector table: start, held goal, pause, simultaneous goals, ticks, ignored start.
        for (int i = 0; i < 20; i++) begin
            step($sformatf("tbl%0d", i), tbl[i].st, tbl[i].g1, tbl[i].g2, tbl[i].tk, tbl[i].e);
        end

        // Seven goals for player 2 end the match; later goals are ignored.
        restart("p2x7_start");
        for (int k = 1; k <= 6; k++) begin
            goal_seq("p2x7", 2, 3'd0, 3'(k), 8'd150);
        end
        step("p2x7_win",  1'b0, 1'b0, 1'b1, 1'b0, mk_e(S_OVER, 3'd0, 3'd7, 8'd150, W_P2, 1'b0, 1'b0));
        step("p2x7_hold", 1'b0, 1'b0, 1'b0, 1'b0, mk_e(S_OVER, 3'd0, 3'd7, 8'd150, W_P2, 1'b0, 1'b0));
        step("p2x7_ign2", 1'b0, 1'b0, 1'b1, 1'b0, mk_e(S_OVER, 3'd0, 3'd7, 8'd150, W_P2, 1'b0, 1'b0));
        step("p2x7_ign1", 1'b0, 1'b1, 1'b0, 1'b1, mk_e(S_OVER, 3'd0, 3'd7, 8'd150, W_P2, 1'b0, 1'b0));

        // Timeout with 2-1: player 1 wins, clock saturates at 0.
        restart("to21_start");
        goal_seq("to21_g1a", 1, 3'd1, 3'd0, 8'd150);
        goal_seq("to21_g1b", 1, 3'd2, 3'd0, 8'd150);
        goal_seq("to21_g2",  2, 3'd2, 3'd1, 8'd150);
        run_ticks("to21_tick", 149, 3'd2, 3'd1);
        step("to21_end", 1'b0, 1'b0, 1'b0, 1'b1, mk_e(S_OVER, 3'd2, 3'd1, 8'd0, W_P1, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++) begin
            step("to21_sat", 1'b0, 1'b0, 1'b0, 1'b1, mk_e(S_OVER, 3'd2, 3'd1, 8'd0, W_P1, 1'b0, 1'b0));
        end

        // Tied timeout.
        restart("tie_start");
        goal_seq("tie_g1", 1, 3'd1, 3'd0, 8'd150);
        goal_seq("tie_g2", 2, 3'd1, 3'd1, 8'd150);
        run_ticks("tie_tick", 149, 3'd1, 3'd1);
`ifdef MATCH_CTRL_SUDDEN_DEATH_EN
        step("sd_enter", 1'b0, 1'b0, 1'b0, 1'b1, mk_e(S_PLAY, 3'd1, 3'd1, 8'd0, W_NONE, 1'b0, 1'b0));
        step("sd_tick",  1'b0, 1'b0, 1'b0, 1'b1, mk_e(S_PLAY, 3'd1, 3'd1, 8'd0, W_NONE, 1'b0, 1'b0));
        step("sd_goal",  1'b0, 1'b1, 1'b0, 1'b0, mk_e(S_OVER, 3'd2, 3'd1, 8'd0, W_P1,   1'b0, 1'b0));
`else
        step("tie_end",  1'b0, 1'b0, 1'b0, 1'b1, mk_e(S_OVER, 3'd1, 3'd1, 8'd0, W_DRAW, 1'b0, 1'b0));
        step("tie_ign",  1'b0, 1'b1, 1'b0, 1'b0, mk_e(S_OVER, 3'd1, 3'd1, 8'd0, W_DRAW, 1'b0, 1'b0));
`endif

        // Goal on the final tick counts before the timeout decision.
        restart("last_start");
        run_ticks("last_tick", 149, 3'd0, 3'd0);
        step("last_goal", 1'b0, 1'b1, 1'b0, 1'b1, mk_e(S_OVER, 3'd1, 3'd0, 8'd0, W_P1, 1'b0, 1'b0));

        // Asynchronous reset mid-PAUSE, then a clean restart.
        restart("rst_start");
        step("rst_goal", 1'b0, 1'b1, 1'b0, 1'b0, mk_e(S_PAUSE, 3'd1, 3'd0, 8'd150, W_NONE, 1'b0, 1'b0));
        step("rst_tick", 1'b0, 1'b0, 1'b0, 1'b1, mk_e(S_PAUSE, 3'd1, 3'd0, 8'd150, W_NONE, 1'b0, 1'b0));
        @(negedge clock);
        #2;
        start = 1'b0; goal_p1 = 1'b0; goal_p2 = 1'b0; sec_tick = 1'b0; reset = 1'b1;
        #1;
        cmp("rst_async", mk_e(S_IDLE, 3'd0, 3'd0, 8'd150, W_NONE, 1'b0, 1'b0));
        @(negedge clock);
        reset = 1'b0;
        step("rst_restart", 1'b1, 1'b0, 1'b0, 1'b0, mk_e(S_PLAY, 3'd0, 3'd0, 8'd150, W_NONE, 1'b1, 1'b1));
        step("rst_clr1",    1'b0, 1'b0, 1'b0, 1'b0, mk_e(S_PLAY, 3'd0, 3'd0, 8'd150, W_NONE, 1'b1, 1'b0));
        step("rst_clr2",    1'b0, 1'b0, 1'b0, 1'b0, mk_e(S_PLAY, 3'd0, 3'd0, 8'd150, W_NONE, 1'b1, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
